// File: rtl/mem_access_master.sv
// Sequences one 16/32-bit load/store into one or two single-cycle word accesses.
// Accept-to-response: 2 cycles narrow, 3 wide, 1 out-of-range; req_ready low while busy, response held until rsp_ready.
module mem_access_master #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_rdata
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACC_LO,
    ACC_HI,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        write_q;
  logic        wide_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_hi;
  logic        out_of_range;

  assign addr_hi = addr_q + 32'd1;

  // The first term also covers req_addr+1 wrapping to zero at the top of the address space.
  assign out_of_range = (req_addr >= MEM_LIMIT) ||
                        (req_wide && ((req_addr + 32'd1) >= MEM_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            wide_q  <= req_wide;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= out_of_range;
            rdata_q <= 32'd0;
          end
        end
        ACC_LO: begin
          if (!write_q) begin
            rdata_q[15:0] <= mem_rdata;
          end
        end
        ACC_HI: begin
          if (!write_q) begin
            rdata_q[31:16] <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Everything is gated by reset so no strobe escapes in the reset cycle.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 16'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            state_d = out_of_range ? RESP : ACC_LO;
          end
        end
        ACC_LO: begin
          mem_addr  = addr_q;
          mem_read  = !write_q;
          mem_write = write_q;
          if (write_q) begin
            mem_wdata = wdata_q[15:0];
          end
          state_d = wide_q ? ACC_HI : RESP;
        end
        ACC_HI: begin
          mem_addr  = addr_hi;
          mem_read  = !write_q;
          mem_write = write_q;
          if (write_q) begin
            mem_wdata = wdata_q[31:16];
          end
          state_d = RESP;
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_rdata = rdata_q;
          rsp_err   = err_q;
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
